// File: rtl/stopwatch_control_if.sv
// Stopwatch control bundle: request levels and counter values in, counter strobes and status out.
// Latency: none, wires only.
// Backpressure: none; every signal is a plain level or pulse.
interface stopwatch_control_if;
    logic       start;
    logic       stop;
    logic       clear;
    logic [5:0] seconds;
    logic [7:0] minutes;
    logic       sec_en;
    logic       min_en;
    logic       cnt_clear;
    logic       running;
    logic       paused;
    logic       overflow;

    // Driver of requests and counter values; observer of strobes and status.
    modport master (
        output start, stop, clear, seconds, minutes,
        input  sec_en, min_en, cnt_clear, running, paused, overflow
    );

    // The stopwatch controller itself.
    modport slave (
        input  start, stop, clear, seconds, minutes,
        output sec_en, min_en, cnt_clear, running, paused, overflow
    );
endinterface

// File: rtl/stopwatch_control.sv
// Stopwatch sequencer: edge-detected start/stop/clear driving a 4-state FSM and a one-second prescaler.
// Latency: every output is registered, so it reflects a request one cycle after the request is sampled.
// Backpressure: none; requests are edge-triggered and strobes are single-cycle pulses.
module stopwatch_control #(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic               clk,
    input  logic               reset,
    stopwatch_control_if.slave sw
);

    localparam int unsigned     PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          start_q, start_d;
    logic          stop_q, stop_d;
    logic          clear_q, clear_d;
    // Start is only honoured once it has been seen low after reset, so a
    // level held through reset release cannot masquerade as a fresh edge.
    logic          start_arm_q, start_arm_d;
    logic          sec_en_q, sec_en_d;
    logic          min_en_q, min_en_d;
    logic          cnt_clear_q, cnt_clear_d;
    logic          running_q, running_d;
    logic          paused_q, paused_d;
    logic          overflow_q, overflow_d;

    logic          start_req, stop_req, clear_req;
    logic          tick, terminal;

    // Next-state, prescaler and output-pulse decode; clear beats stop beats start.
    always_comb begin
        start_req = sw.start & ~start_q & start_arm_q;
        stop_req  = sw.stop  & ~stop_q;
        clear_req = sw.clear & ~clear_q;
        tick      = (state_q == S_RUN) && (presc_q == PRESC_MAX);
        terminal  = (sw.minutes == 8'd255) && (sw.seconds == 6'd59);

        state_d     = state_q;
        presc_d     = presc_q;
        sec_en_d    = 1'b0;
        min_en_d    = 1'b0;
        cnt_clear_d = 1'b0;

        // Prescaler advances on every RUN cycle, including the one that leaves RUN,
        // so a pause keeps exactly the elapsed part of the current second.
        if (state_q == S_RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    cnt_clear_d = 1'b1;
                end else if (start_req) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (clear_req) begin
                    state_d     = S_IDLE;
                    cnt_clear_d = 1'b1;
                end else if (stop_req) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    if (terminal) begin
                        state_d = S_DONE;
                    end else begin
                        sec_en_d = 1'b1;
                        min_en_d = (sw.seconds == 6'd59);
                    end
                end
            end
            S_PAUSE: begin
                if (clear_req) begin
                    state_d     = S_IDLE;
                    cnt_clear_d = 1'b1;
                end else if (start_req) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (clear_req) begin
                    state_d     = S_IDLE;
                    cnt_clear_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (clear_req) begin
            presc_d = '0;
        end

        start_d     = sw.start;
        stop_d      = sw.stop;
        clear_d     = sw.clear;
        start_arm_d = start_arm_q | ~sw.start;

        running_d  = (state_d == S_RUN);
        paused_d   = (state_d == S_PAUSE);
        overflow_d = (state_d == S_DONE);
    end

    // State, prescaler, edge-detect and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            clear_q     <= 1'b0;
            start_arm_q <= 1'b0;
            sec_en_q    <= 1'b0;
            min_en_q    <= 1'b0;
            cnt_clear_q <= 1'b0;
            running_q   <= 1'b0;
            paused_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            clear_q     <= clear_d;
            start_arm_q <= start_arm_d;
            sec_en_q    <= sec_en_d;
            min_en_q    <= min_en_d;
            cnt_clear_q <= cnt_clear_d;
            running_q   <= running_d;
            paused_q    <= paused_d;
            overflow_q  <= overflow_d;
        end
    end

    assign sw.sec_en    = sec_en_q;
    assign sw.min_en    = min_en_q;
    assign sw.cnt_clear = cnt_clear_q;
    assign sw.running   = running_q;
    assign sw.paused    = paused_q;
    assign sw.overflow  = overflow_q;

endmodule

// File: tb/tb_stopwatch_control.sv
// Bench for stopwatch_control at TICK_DIV=4: vector table, directed corner sequences, random run vs model.
// Latency: outputs are compared one clock after the inputs that cause them.
// Backpressure: not applicable.
module tb_stopwatch_control;

    localparam int TD = 4;

    logic clk = 1'b0;
    logic reset;

    stopwatch_control_if sw ();

    stopwatch_control #(.TICK_DIV(TD)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw)
    );

    always #5 clk = ~clk;

    // Output vector order: {sec_en, min_en, cnt_clear, running, paused, overflow}
    logic [5:0] dut_o;
    assign dut_o = {sw.sec_en, sw.min_en, sw.cnt_clear, sw.running, sw.paused, sw.overflow};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model, described in terms of elapsed running time.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int         m_mode;
    int         m_run_cycles;      // cycles spent running since the last clear
    logic       m_prev_st, m_prev_sp, m_prev_cl, m_armed;
    logic [5:0] m_exp;

    task automatic model_step(input logic rst, st, sp, cl, input logic [5:0] sec, input logic [7:0] mn);
        logic sreq, preq, creq, ticking, e_sec, e_min, e_clr;
        if (rst) begin
            m_mode = M_IDLE; m_run_cycles = 0;
            m_prev_st = 0; m_prev_sp = 0; m_prev_cl = 0; m_armed = 0;
            m_exp = 6'b0;
            return;
        end
        sreq = st && !m_prev_st && m_armed;
        preq = sp && !m_prev_sp;
        creq = cl && !m_prev_cl;
        ticking = (m_mode == M_RUN) && ((m_run_cycles % TD) == TD - 1);
        e_sec = 0; e_min = 0; e_clr = 0;
        if (m_mode == M_RUN) m_run_cycles++;
        if (creq) begin
            e_clr = 1; m_mode = M_IDLE; m_run_cycles = 0;
        end else begin
            case (m_mode)
                M_IDLE:  if (sreq) m_mode = M_RUN;
                M_PAUSE: if (sreq) m_mode = M_RUN;
                M_RUN: begin
                    if (preq) m_mode = M_PAUSE;
                    else if (ticking) begin
                        if (mn == 8'd255 && sec == 6'd59) m_mode = M_DONE;
                        else begin e_sec = 1; e_min = (sec == 6'd59); end
                    end
                end
                default: ;
            endcase
        end
        m_armed = m_armed | !st;
        m_prev_st = st; m_prev_sp = sp; m_prev_cl = cl;
        m_exp = {e_sec, e_min, e_clr, m_mode == M_RUN, m_mode == M_PAUSE, m_mode == M_DONE};
    endtask

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b, expected %b (sec_en,min_en,cnt_clear,running,paused,overflow)",
                     name, $time, act, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, and compare against the model.
    task automatic cyc(input logic rst, st, sp, cl, input logic [5:0] sec, input logic [7:0] mn);
        reset = rst; sw.start = st; sw.stop = sp; sw.clear = cl; sw.seconds = sec; sw.minutes = mn;
        model_step(rst, st, sp, cl, sec, mn);
        @(posedge clk);
        #1;
        check("model", dut_o, m_exp);
    endtask

    typedef struct {
        logic       rst, st, sp, cl;
        logic [5:0] sec;
        logic [7:0] mn;
        logic [5:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic rst, st, sp, cl, input logic [5:0] sec, input logic [7:0] mn,
                       input logic [5:0] exp);
        vec_t v;
        v.rst = rst; v.st = st; v.sp = sp; v.cl = cl; v.sec = sec; v.mn = mn; v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        logic st, sp, cl, rs;
        reset = 1'b1; sw.start = 0; sw.stop = 0; sw.clear = 0; sw.seconds = 0; sw.minutes = 0;

        // Vector table: reset, start, ticks, minute carry, pause/resume with remaining cycles, clear.
        add(1,0,0,0, 0,0, 6'b000000);
        add(1,0,0,0, 0,0, 6'b000000);
        add(0,0,0,0,10,0, 6'b000000);
        add(0,1,0,0,10,0, 6'b000100);   // start edge -> running next cycle
        add(0,1,0,0,10,0, 6'b000100);
        add(0,1,0,0,10,0, 6'b000100);
        add(0,1,0,0,10,0, 6'b000100);
        add(0,1,0,0,10,0, 6'b100100);   // first sec_en 4 cycles after running
        add(0,0,0,0,20,0, 6'b000100);
        add(0,0,0,0,20,0, 6'b000100);
        add(0,0,0,0,59,3, 6'b000100);
        add(0,0,0,0,59,3, 6'b110100);   // seconds=59 -> sec_en and min_en together
        add(0,0,0,0, 0,4, 6'b000100);
        add(0,0,1,0, 0,4, 6'b000010);   // stop 2 cycles after tick
        add(0,0,0,0, 0,4, 6'b000010);
        add(0,0,1,0, 0,4, 6'b000010);   // stop edge in PAUSE ignored
        for (int i = 0; i < 8; i++) add(0,0,0,0, 0,4, 6'b000010);
        add(0,1,0,0, 5,4, 6'b000100);   // resume
        add(0,1,0,0, 5,4, 6'b000100);
        add(0,1,0,0, 5,4, 6'b100100);   // remaining 2 cycles only
        add(0,1,0,1, 5,4, 6'b001000);   // clear -> IDLE with cnt_clear
        add(0,0,0,1, 5,4, 6'b000000);   // held clear is not a new request
        add(0,0,0,0, 5,4, 6'b000000);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].sec, tbl[i].mn);
            check($sformatf("vec%0d", i), dut_o, tbl[i].exp);
        end

        // Terminal tick into DONE; start/stop ignored; clear returns to IDLE.
        cyc(0,1,0,0,59,255); check("ovf_start", dut_o, 6'b000100);
        for (int i = 0; i < 3; i++) begin cyc(0,1,0,0,59,255); check("ovf_run", dut_o, 6'b000100); end
        cyc(0,1,0,0,59,255); check("ovf_terminal", dut_o, 6'b000001);
        cyc(0,0,0,0,59,255); check("ovf_hold", dut_o, 6'b000001);
        cyc(0,1,0,0,59,255); check("ovf_start_ign", dut_o, 6'b000001);
        cyc(0,1,1,0,59,255); check("ovf_stop_ign", dut_o, 6'b000001);
        cyc(0,0,0,1,59,255); check("ovf_clear", dut_o, 6'b001000);
        cyc(0,0,0,0,59,255); check("ovf_idle", dut_o, 6'b000000);

        // Stop and clear together on the tick cycle: clear wins, no sec_en.
        cyc(0,1,0,0,0,0); check("tc_start", dut_o, 6'b000100);
        for (int i = 0; i < 3; i++) cyc(0,1,0,0,0,0);
        cyc(0,1,1,1,0,0); check("tc_clear_on_tick", dut_o, 6'b001000);
        cyc(0,0,0,0,0,0); check("tc_idle", dut_o, 6'b000000);

        // Clear from PAUSE mid-second must zero the prescaler.
        cyc(0,1,0,0,0,0); check("pc_start", dut_o, 6'b000100);
        cyc(0,1,0,0,0,0);
        cyc(0,1,1,0,0,0); check("pc_pause", dut_o, 6'b000010);
        cyc(0,0,0,1,0,0); check("pc_clear", dut_o, 6'b001000);
        cyc(0,0,0,0,0,0);
        cyc(0,1,0,0,0,0); check("pc_restart", dut_o, 6'b000100);
        for (int i = 0; i < 3; i++) begin cyc(0,1,0,0,0,0); check("pc_no_early_tick", dut_o, 6'b000100); end
        cyc(0,1,0,0,0,0); check("pc_full_second", dut_o, 6'b100100);

        // Reset mid-RUN with start held; start must toggle before running again.
        cyc(1,1,0,0,0,0); check("rst_in_run", dut_o, 6'b000000);
        for (int i = 0; i < 3; i++) begin cyc(0,1,0,0,0,0); check("rst_held_start", dut_o, 6'b000000); end
        cyc(0,0,0,0,0,0); check("rst_start_low", dut_o, 6'b000000);
        cyc(0,1,0,0,0,0); check("rst_start_toggle", dut_o, 6'b000100);

        // Randomized run against the model.
        st = 1; sp = 0; cl = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] sec;
            logic [7:0] mn;
            if ($urandom_range(0, 5) == 0)  st = ~st;
            if ($urandom_range(0, 7) == 0)  sp = ~sp;
            if ($urandom_range(0, 19) == 0) cl = ~cl;
            rs  = ($urandom_range(0, 299) == 0);
            sec = ($urandom_range(0, 3) == 0) ? 6'd59 : 6'($urandom_range(0, 59));
            mn  = ($urandom_range(0, 2) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
            cyc(rs, st, sp, cl, sec, mn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_control.md
STOPWATCH_CONTROL -- requirements
Module: stopwatch_control

Interface
REQ-001 Parameter TICK_DIV, default 100000000, SHALL set the number of clk cycles per one-second tick; legal range 2 to 2^27.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 start  input  1  SHALL be a level input; only its rising edge SHALL act as a start/resume request.
REQ-005 stop  input  1  SHALL be a level input; only its rising edge SHALL act as a pause request.
REQ-006 clear  input  1  SHALL be a level input; only its rising edge SHALL act as a clear request.
REQ-007 seconds  input  6  SHALL carry the current seconds-counter value (0-59).
REQ-008 minutes  input  8  SHALL carry the current minutes-counter value (0-255).
REQ-009 sec_en  output  1  SHALL be a one-cycle increment pulse to the seconds counter.
REQ-010 min_en  output  1  SHALL be a one-cycle increment pulse to the minutes counter.
REQ-011 cnt_clear  output  1  SHALL be a one-cycle clear pulse to both counters.
REQ-012 running  output  1  SHALL be high exactly while state is RUN.
REQ-013 paused  output  1  SHALL be high exactly while state is PAUSE.
REQ-014 overflow  output  1  SHALL be high exactly while state is DONE.

Function
REQ-015 Edge detection SHALL register start, stop and clear once each; a request SHALL be input high while its registered copy is low.
REQ-016 The FSM SHALL have four states: IDLE, RUN, PAUSE, DONE.
REQ-017 Request priority in one cycle SHALL be clear > stop > start.
REQ-018 IDLE: start goes to RUN; clear stays IDLE and pulses cnt_clear; stop is ignored.
REQ-019 RUN: clear goes to IDLE and pulses cnt_clear; otherwise stop goes to PAUSE; start is ignored.
REQ-020 PAUSE: clear goes to IDLE and pulses cnt_clear; otherwise start goes to RUN; stop is ignored.
REQ-021 DONE: clear goes to IDLE and pulses cnt_clear; start and stop are ignored.
REQ-022 The prescaler SHALL be ceil(log2(TICK_DIV)) bits wide.
REQ-023 The prescaler SHALL increment only in RUN and wrap from TICK_DIV-1 to 0; wrap is the tick.
REQ-024 The prescaler SHALL be zeroed on reset and on every clear request.
REQ-025 In PAUSE the prescaler SHALL hold its value, so a resumed second completes after the remaining cycles only.
REQ-026 sec_en SHALL be registered and asserted for exactly the one cycle after a tick.
REQ-027 From a zeroed prescaler, the first sec_en SHALL occur TICK_DIV cycles after state becomes RUN, then every TICK_DIV cycles.
REQ-028 min_en SHALL be asserted in the same cycle as sec_en only when seconds == 59 at the tick.
REQ-029 Terminal tick (minutes == 255 and seconds == 59) SHALL assert neither sec_en nor min_en and SHALL move RUN to DONE.
REQ-030 A stop or clear request in the same cycle as a tick SHALL take priority; sec_en and min_en SHALL not pulse for that tick.
REQ-031 sec_en, min_en and cnt_clear SHALL be mutually exclusive with cnt_clear; no output pulse SHALL exceed one cycle.

Reset
REQ-032 While reset is high, the FSM SHALL go to IDLE and the prescaler and edge-detect registers SHALL be zeroed.
REQ-033 While reset is high, sec_en, min_en, cnt_clear, running, paused and overflow SHALL all be 0.
REQ-034 Reset SHALL override all requests in the same cycle, including mid-RUN or mid-PAUSE.
REQ-035 A start level held high through reset release SHALL NOT be treated as a request until it is seen low and then high.

Verification (TICK_DIV=4)
REQ-036 Start edge from IDLE -> running=1 next cycle; sec_en pulses 4 cycles later and then every 4 cycles; min_en stays 0 while seconds < 59.
REQ-037 seconds=59, minutes=3, tick in RUN -> sec_en=1 and min_en=1 in the same single cycle.
REQ-038 Stop edge 2 cycles after a tick, wait 10 cycles, then start -> paused=1 throughout the wait, no sec_en; next sec_en comes 2 cycles after RUN resumes.
REQ-039 seconds=59, minutes=255, tick -> no sec_en or min_en, overflow=1; start/stop ignored; clear -> cnt_clear one cycle, state IDLE, overflow=0.
REQ-040 Stop and clear edges in the same cycle as a pending tick -> cnt_clear=1, sec_en=0, state IDLE, prescaler 0.
REQ-041 Reset asserted in RUN with start held high -> all outputs 0 next cycle; after release, no RUN until start toggles low then high.
